// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// One op is accepted per start pulse while idle; the result lands in HI/LO when the busy period ends.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is a one-cycle request; it is accepted only when busy=0
  // and silently dropped otherwise. busy=1 means a MULT/DIV result is pending.

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [0:0]       state;

  assign state = (cnt == '0) ? ST_IDLE : ST_RUN;

  // Datapath works only on latched operands, so a/b may change freely during RUN.
  logic                 is_signed;
  logic                 is_div;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   prod;
  logic                 neg_a;
  logic                 neg_b;
  logic                 b_zero;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    neg_a     = is_signed & a_q[WIDTH-1];
    neg_b     = is_signed & b_q[WIDTH-1];
    b_zero    = (b_q == '0);

    // Sign-extending to 2W makes the low 2W bits of one multiplier correct for both flavours.
    ext_a = {{WIDTH{neg_a}}, a_q};
    ext_b = {{WIDTH{neg_b}}, b_q};
    prod  = ext_a * ext_b;

    // Magnitude divide: |-2^(W-1)| still fits unsigned, which yields the overflow case for free.
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    q_mag = '0;
    r_mag = '0;
    if (!b_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem  = neg_a ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
                cnt  <= MUL_LOAD;
                busy <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
                cnt  <= DIV_LOAD;
                busy <= 1'b1;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        default: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            busy <= 1'b0;
            if (!is_div) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (!b_zero) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
      endcase
    end
  end

endmodule
